// File: rtl/mux_pkg.sv
// Shared helpers for the processor's datapath muxes:
// default payload width and channel-index width derivation.
package mux_pkg;

    localparam int DEF_WIDTH = 64;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// Valid/ready bundle for an N-to-1 arbitrated mux:
// N request channels in, one registered beat out.
interface rr_mux_arb_if
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = 4,
    parameter int SEL_W = sel_w(N)
);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/rr_mux_arb_arbiter.sv
// Combinational arbiter: round-robin from ptr, or
// fixed priority from channel 0; grant is one-hot or zero.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             rr_en,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             any
);

    // Scan channels from the start point, wrapping at N explicitly
    always_comb begin
        int base;
        int j;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        base      = rr_en ? int'(ptr) : 0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = base + k;
            if (j >= N) j = j - N;
            for (int i = 0; i < N; i++) begin
                if (!any && i == j && req[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = SEL_W'(i);
                    any       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// Registered N-to-1 mux with internal arbitration;
// holds one output beat and the round-robin pointer.
module rr_mux_arb
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = 4,
    parameter int SEL_W = sel_w(N)
) (
    input logic         clk,
    input logic         reset_n,
    input logic         rr_en,
    rr_mux_arb_if.slave bus
);

    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic             any;
    logic             load;
    logic [WIDTH-1:0] data_sel;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
        .req       (bus.in_valid),
        .ptr       (ptr_q),
        .rr_en     (rr_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // Register is free when empty or draining this cycle
    assign load         = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = grant & {N{load}};

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

    // AND-OR data select over the one-hot grant
    always_comb begin
        data_sel = '0;
        for (int i = 0; i < N; i++) begin
            data_sel = data_sel
                     | (bus.in_data[i*WIDTH +: WIDTH]
                     & {WIDTH{grant[i]}});
        end
    end

    // Next state: load a granted beat, or empty on an idle load
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = any;
            if (any) begin
                out_data_d = data_sel;
                out_sel_d  = grant_idx;
                if (rr_en) begin
                    if (grant_idx == SEL_W'(N - 1))
                        ptr_d = '0;
                    else
                        ptr_d = grant_idx + SEL_W'(1);
                end
            end
        end
    end

    // Output holding register and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb: directed vector table, hand sequences
// and a randomized run against a queue-level reference model.
module tb_rr_mux_arb;

    logic clk;
    logic reset_n;
    logic rr4;
    logic rr3;

    int total;
    int bad;

    rr_mux_arb_if #(.WIDTH(64), .N(4)) b4 ();
    rr_mux_arb_if #(.WIDTH(64), .N(3)) b3 ();

    rr_mux_arb #(.WIDTH(64), .N(4)) u4 (
        .clk     (clk),
        .reset_n (reset_n),
        .rr_en   (rr4),
        .bus     (b4)
    );

    rr_mux_arb #(.WIDTH(64), .N(3)) u3 (
        .clk     (clk),
        .reset_n (reset_n),
        .rr_en   (rr3),
        .bus     (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rr;
        logic [3:0] v;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] sel;
    } vec_t;

    vec_t tbl[21];

    // reference model state
    bit          m_valid;
    logic [63:0] m_data;
    int          m_sel;
    int          m_ptr;
    bit   [3:0]  pend;
    logic [63:0] pdata[4];

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h",
                     nm, act, exp);
        end
    endtask

    function automatic logic [63:0] cdat(input int i);
        return (i == 2) ? 64'hDEAD_BEEF : 64'hC0 + 64'(i);
    endfunction

    function automatic int mgrant(input bit [3:0] v,
                                  input bit rr,
                                  input int p);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = rr ? (p + k) % 4 : k;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic run_vec(input vec_t t, input string nm);
        rr4 = t.rr;
        b4.in_valid = t.v;
        b4.out_ready = t.ordy;
        #1;
        chk({nm, "_rdy"}, 64'(b4.in_ready), 64'(t.rdy));
        @(posedge clk);
        #1;
        chk({nm, "_ov"}, 64'(b4.out_valid), 64'(t.ov));
        chk({nm, "_sel"}, 64'(b4.out_sel), 64'(t.sel));
        if (t.ov)
            chk({nm, "_dat"}, b4.out_data, cdat(int'(t.sel)));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int g;
        bit ld;
        logic [3:0] er;
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        rr4 = 1'b1;
        rr3 = 1'b1;
        b4.in_valid = '0;
        b4.out_ready = 1'b1;
        b3.in_valid = '0;
        b3.out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            b4.in_data[i*64 +: 64] = cdat(i);
        for (int i = 0; i < 3; i++)
            b3.in_data[i*64 +: 64] = 64'hA0 + 64'(i);

        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[3]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[5]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[6]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[7]  = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[8]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3};
        tbl[9]  = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[10] = '{1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[11] = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[12] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[13] = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[14] = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[15] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[16] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[17] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[18] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[19] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[20] = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};

        // reset state
        #1;
        chk("rst_ov", 64'(b4.out_valid), 64'd0);
        chk("rst_dat", b4.out_data, 64'd0);
        chk("rst_sel", 64'(b4.out_sel), 64'd0);
        chk("rst3_ov", 64'(b3.out_valid), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // directed table
        for (int n = 0; n < 21; n++)
            run_vec(tbl[n], $sformatf("vec%0d", n));

        // randomized run against the reference model
        b4.in_valid = '0;
        do_reset();
        m_valid = 0;
        m_data = '0;
        m_sel = 0;
        m_ptr = 0;
        pend = '0;
        rr4 = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    pdata[i] = {$urandom, $urandom};
                end
                b4.in_data[i*64 +: 64] = pdata[i];
            end
            if ($urandom_range(7, 0) == 0) rr4 = ~rr4;
            b4.out_ready = ($urandom_range(3, 0) != 0);
            b4.in_valid = pend;
            #1;
            g = mgrant(pend, rr4, m_ptr);
            ld = !m_valid || b4.out_ready;
            er = (ld && g >= 0) ? 4'(1 << g) : 4'd0;
            chk("rnd_rdy", 64'(b4.in_ready), 64'(er));
            if (ld) begin
                if (g >= 0) begin
                    m_valid = 1;
                    m_data = pdata[g];
                    m_sel = g;
                    if (rr4) m_ptr = (g + 1) % 4;
                    pend[g] = 1'b0;
                end else begin
                    m_valid = 0;
                end
            end
            @(posedge clk);
            #1;
            chk("rnd_ov", 64'(b4.out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("rnd_sel", 64'(b4.out_sel), 64'(m_sel));
                chk("rnd_dat", b4.out_data, m_data);
            end
        end

        // asynchronous reset with a beat held
        for (int i = 0; i < 4; i++)
            b4.in_data[i*64 +: 64] = cdat(i);
        rr4 = 1'b1;
        b4.in_valid = 4'b1111;
        b4.out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_held", 64'(b4.out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_ov", 64'(b4.out_valid), 64'd0);
        chk("mid_dat", b4.out_data, 64'd0);
        chk("mid_sel", 64'(b4.out_sel), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_vec('{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0},
                "post_rst");

        // non-power-of-two wrap on the 3-channel instance
        b3.in_valid = 3'b111;
        b3.out_ready = 1'b1;
        rr3 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("n3_rdy", 64'(b3.in_ready), 64'(1 << (k % 3)));
            @(posedge clk);
            #1;
            chk("n3_ov", 64'(b3.out_valid), 64'd1);
            chk("n3_sel", 64'(b3.out_sel), 64'(k % 3));
            chk("n3_dat", b3.out_data, 64'hA0 + 64'(k % 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
